life_grid_reader: RTL

LIFE_GRID_READER -- requirements
Module: life_grid_reader

---
 rtl/life_grid_reader_if.sv | 26 ++
 rtl/life_grid_reader.sv | 113 +++++++++++
 2 files changed

// File: rtl/life_grid_reader_if.sv
// Row stream from the grid reader: one 16-bit board row plus its index per transfer.
// A transfer occurs on a rising clock edge where row_valid && row_ready; while
// row_valid is high and row_ready is low, row_data/row_idx/row_last hold steady.
interface life_grid_reader_if;
    logic [15:0] row_data;
    logic [3:0]  row_idx;
    logic        row_valid;
    logic        row_ready;
    logic        row_last;

    modport master (
        output row_data,
        output row_idx,
        output row_valid,
        output row_last,
        input  row_ready
    );

    modport slave (
        input  row_data,
        input  row_idx,
        input  row_valid,
        input  row_last,
        output row_ready
    );
endinterface

// File: rtl/life_grid_reader.sv
// Snapshots a 16x16 life board on start and streams it row by row over a
// valid/ready link, reporting the frame's live-cell count when the frame completes.
module life_grid_reader #(
    parameter bit REVERSE = 1'b0
) (
    input  logic                       clk,
    input  logic                       areset,
    input  logic                       start,
    input  logic [255:0]               grid,
    life_grid_reader_if.master         row,
    output logic                       busy,
    output logic                       done,
    output logic [8:0]                 pop_count,
    output logic [1:0]                 state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] FIRST_IDX = REVERSE ? 4'd15 : 4'd0;
    localparam logic [3:0] LAST_IDX  = REVERSE ? 4'd0  : 4'd15;
    localparam logic [3:0] IDX_STEP  = REVERSE ? 4'hF  : 4'h1;

    state_t       cur_state;
    state_t       nxt_state;
    logic [255:0] shadow;
    logic [3:0]   idx;
    logic [8:0]   run_count;
    logic [15:0]  cur_row;
    logic [4:0]   row_pop;
    logic         xfer;
    logic         at_last;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) begin
            n = n + {4'd0, v[i]};
        end
        return n;
    endfunction

    // Rows are read only from the shadow copy, so the live board may change freely.
    assign cur_row = shadow[{idx, 4'b0000} +: 16];
    assign row_pop = popcount16(cur_row);
    assign at_last = (idx == LAST_IDX);
    assign xfer    = (cur_state == SEND) && row.row_ready;

    assign row.row_data  = cur_row;
    assign row.row_idx   = idx;
    assign row.row_valid = (cur_state == SEND);
    assign row.row_last  = (cur_state == SEND) && at_last;
    assign busy          = (cur_state == SEND) || (cur_state == DONE);
    assign done          = (cur_state == DONE);
    assign state         = cur_state;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            cur_state <= IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            IDLE: begin
                if (start) begin
                    nxt_state = SEND;
                end
            end
            SEND: begin
                if (xfer && at_last) begin
                    nxt_state = DONE;
                end
            end
            DONE: begin
                nxt_state = IDLE;
            end
            default: begin
                nxt_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            shadow    <= '0;
            idx       <= '0;
            run_count <= '0;
            pop_count <= '0;
        end else begin
            if (cur_state == IDLE && start) begin
                shadow    <= grid;
                idx       <= FIRST_IDX;
                run_count <= '0;
            end else if (xfer) begin
                run_count <= run_count + {4'd0, row_pop};
                if (at_last) begin
                    // Published on the final transfer so it is already valid while done is high.
                    pop_count <= run_count + {4'd0, row_pop};
                end else begin
                    idx <= idx + IDX_STEP;
                end
            end
        end
    end

endmodule
